i2c_cmd_arbiter: RTL and testbench

Shares one I2C master (start/rw/addr/data_in in, done/data_out back) among NREQ command requesters. It picks requesters by round-robin, issues exactly one start pulse per transaction, and waits for completion or timeout. It then returns read data and status to the granted requester. It sits between the system-side command sources and the I2C master.

---
 rtl/i2c_arb_pkg.sv | 6 +
 rtl/rr_arbiter.sv | 23 ++
 rtl/i2c_cmd_arbiter.sv | 90 +++++++++
 tb/tb_i2c_cmd_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/i2c_arb_pkg.sv
// i2c_arb_pkg: shared state encoding and bus widths for the I2C command arbiter
package i2c_arb_pkg;
  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);
  logic [NREQ-1:0] mask, cand;
  always_comb begin
    mask = '0;
    for (int i = 0; i < NREQ; i++) mask[i] = i >= int'(ptr);
  end
  // fall back to the unmasked requests when nothing sits at or above ptr
  assign cand = |(req & mask) ? req & mask : req;
  assign gnt = cand & (~cand + NREQ'(1));
  always_comb begin
    idx = '0;
    for (int i = 0; i < NREQ; i++) if (gnt[i]) idx = IW'(i);
  end
endmodule

// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter: round-robin sharing of one I2C master among NREQ command requesters
module i2c_cmd_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            req_rw,
  input  logic [I2C_ADDR_W*NREQ-1:0] req_addr,
  input  logic [I2C_DATA_W*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            ack,
  output logic [I2C_DATA_W-1:0]      rsp_rdata,
  output logic                       rsp_err,
  output logic                       m_start,
  output logic                       m_rw,
  output logic [I2C_ADDR_W-1:0]      m_addr,
  output logic [I2C_DATA_W-1:0]      m_data_in,
  input  logic                       m_done,
  input  logic [I2C_DATA_W-1:0]      m_data_out
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  state_t st;
  logic [IW-1:0] ptr, own, pick_idx;
  logic [NREQ-1:0] pick;
  logic [CW-1:0] cnt;
  logic m_done_q, done_rise;
  // only a fresh rising edge counts, so a done level left over from a prior command is ignored
  assign done_rise = m_done && !m_done_q;
  rr_arbiter #(.NREQ(NREQ)) u_rr (.req(req), .ptr(ptr), .gnt(pick), .idx(pick_idx));
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      ptr <= '0;
      own <= '0;
      cnt <= '0;
      m_done_q <= 1'b0;
      gnt <= '0;
      ack <= '0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      m_start <= 1'b0;
      m_rw <= 1'b0;
      m_addr <= '0;
      m_data_in <= '0;
    end else begin
      m_done_q <= m_done;
      m_start <= 1'b0;
      ack <= '0;
      case (st)
        IDLE: if (|req) begin
          gnt <= pick;
          own <= pick_idx;
          m_rw <= req_rw[pick_idx];
          m_addr <= req_addr[pick_idx*I2C_ADDR_W +: I2C_ADDR_W];
          m_data_in <= req_wdata[pick_idx*I2C_DATA_W +: I2C_DATA_W];
          m_start <= 1'b1;
          st <= ISSUE;
        end
        ISSUE: begin
          cnt <= '0;
          st <= WAIT;
        end
        WAIT: if (done_rise) begin
          rsp_rdata <= m_data_out;
          rsp_err <= 1'b0;
          ack <= gnt;
          st <= RESP;
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          rsp_rdata <= '0;
          rsp_err <= 1'b1;
          ack <= gnt;
          st <= RESP;
        end else begin
          cnt <= cnt + 1'b1;
        end
        RESP: begin
          gnt <= '0;
          ptr <= own == IW'(NREQ - 1) ? '0 : own + 1'b1;
          st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// tb_i2c_cmd_arbiter: vector table plus corner sequences, responses checked through an expected-ack queue
module tb_i2c_cmd_arbiter;
  localparam int NR = 4;
  localparam int TO = 64;
  logic clk = 1'b0;
  logic rst;
  logic [NR-1:0] req, req_rw, gnt, ack;
  logic [7*NR-1:0] req_addr;
  logic [8*NR-1:0] req_wdata;
  logic [7:0] rsp_rdata, m_data_in, m_data_out;
  logic rsp_err, m_start, m_rw, m_done;
  logic [6:0] m_addr;

  always #5 clk = ~clk;

  i2c_cmd_arbiter #(.NREQ(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .ack(ack), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .m_start(m_start), .m_rw(m_rw), .m_addr(m_addr),
    .m_data_in(m_data_in), .m_done(m_done), .m_data_out(m_data_out)
  );

  typedef struct packed {logic [NR-1:0] ack; logic [7:0] rdata; logic err;} exp_t;
  typedef struct {logic [NR-1:0] r; int idx; logic rw; logic [6:0] addr; logic [7:0] wdata; int delay; logic [7:0] rd;} vec_t;
  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[6];
  int tests = 0, fails = 0, ack_cnt = 0, a0;
  bit start_q = 1'b0;
  logic f_rw[NR];
  logic [6:0] f_addr[NR];
  logic [7:0] f_wdata[NR];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (m_start && start_q) begin
        tests++;
        fails++;
        $display("FAIL start_twice: m_start high 2 cycles, required 1");
      end
      if (ack != '0) begin
        ack_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_ack: got %0h expected none", ack);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_ack", 32'(ack), 32'(mon_e.ack));
          chk("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.rdata));
          chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
        end
      end
    end
    start_q = m_start;
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: run did not finish within 20000 cycles");
    $fatal(1, "watchdog");
  end

  task automatic set_fields(input int idx, input logic rw, input logic [6:0] a, input logic [7:0] w);
    for (int i = 0; i < NR; i++) begin
      f_rw[i] = (i == idx) ? rw : ~rw;
      f_addr[i] = (i == idx) ? a : ~a ^ 7'(i);
      f_wdata[i] = (i == idx) ? w : ~w ^ 8'(i);
      req_rw[i] = f_rw[i];
      req_addr[i*7 +: 7] = f_addr[i];
      req_wdata[i*8 +: 8] = f_wdata[i];
    end
  endtask

  // delay < 0: master never answers; otherwise done rises delay cycles after the start cycle
  task automatic txn(input logic [NR-1:0] r, input int idx, input int delay, input logic [7:0] rd,
                     input bit hold, input bit keep_done);
    logic err;
    int n, exp_n;
    bit gnt_ok;
    err = delay < 0;
    exp_n = err ? TO + 1 : delay + 1;
    req = r;
    exp_q.push_back(exp_t'{NR'(1 << idx), err ? 8'h00 : rd, err});
    @(negedge clk);
    chk("start", 32'(m_start), 1);
    chk("gnt", 32'(gnt), 1 << idx);
    chk("m_addr", 32'(m_addr), 32'(f_addr[idx]));
    chk("m_data_in", 32'(m_data_in), 32'(f_wdata[idx]));
    chk("m_rw", 32'(m_rw), 32'(f_rw[idx]));
    if (!hold) req = '0;
    m_data_out = rd;
    n = 0;
    gnt_ok = 1'b1;
    while (ack == '0 && n < 2 * TO + 8) begin
      if (delay >= 0 && n == delay) m_done = 1'b1;
      @(negedge clk);
      n++;
      if (gnt != NR'(1 << idx)) gnt_ok = 1'b0;
    end
    if (!keep_done) m_done = 1'b0;
    chk("ack_time", n, exp_n);
    chk("gnt_held", 32'(gnt_ok), 1);
    @(negedge clk);
    chk("gnt_clear", 32'(gnt), 0);
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    req_rw = '0;
    req_addr = '0;
    req_wdata = '0;
    m_done = 1'b0;
    m_data_out = '0;
    vecs[0] = '{4'b0001, 0, 1'b0, 7'h50, 8'hA5, 40, 8'h3C};
    vecs[1] = '{4'b0100, 2, 1'b1, 7'h50, 8'h00, 12, 8'h5A};
    vecs[2] = '{4'b1001, 3, 1'b0, 7'h11, 8'h77, 3, 8'h01};
    vecs[3] = '{4'b1010, 1, 1'b1, 7'h7F, 8'h00, 1, 8'hFF};
    vecs[4] = '{4'b0011, 0, 1'b0, 7'h08, 8'h80, 1, 8'h00};
    vecs[5] = '{4'b1100, 2, 1'b1, 7'h2A, 8'h00, TO, 8'h96};
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_start", 32'(m_start), 0);
    chk("rst_addr", 32'(m_addr), 0);
    chk("rst_rdata", 32'(rsp_rdata), 0);
    chk("rst_err", 32'(rsp_err), 0);
    rst = 1'b0;
    // all four requesting continuously from ptr=0
    for (int i = 0; i < NR; i++) begin
      f_rw[i] = i[0];
      f_addr[i] = 7'h10 + 7'(i);
      f_wdata[i] = 8'hA0 + 8'(i);
      req_rw[i] = f_rw[i];
      req_addr[i*7 +: 7] = f_addr[i];
      req_wdata[i*8 +: 8] = f_wdata[i];
    end
    for (int k = 0; k < 5; k++) txn(4'b1111, k % NR, 2, 8'hC0 + 8'(k), k < 4, 1'b0);
    for (int v = 0; v < 6; v++) begin
      set_fields(vecs[v].idx, vecs[v].rw, vecs[v].addr, vecs[v].wdata);
      txn(vecs[v].r, vecs[v].idx, vecs[v].delay, vecs[v].rd, 1'b0, 1'b0);
    end
    // timeout, then a normal transaction
    set_fields(3, 1'b1, 7'h3B, 8'h00);
    txn(4'b1000, 3, -1, 8'hEE, 1'b0, 1'b0);
    set_fields(1, 1'b0, 7'h22, 8'h5C);
    txn(4'b0010, 1, 2, 8'h44, 1'b0, 1'b0);
    // done left high: the next command must wait for a fresh edge
    set_fields(2, 1'b1, 7'h61, 8'h00);
    txn(4'b0100, 2, 2, 8'h61, 1'b0, 1'b1);
    set_fields(0, 1'b1, 7'h45, 8'h00);
    m_data_out = 8'h9B;
    req = 4'b0001;
    exp_q.push_back(exp_t'{4'b0001, 8'h9B, 1'b0});
    @(negedge clk);
    chk("stale_start", 32'(m_start), 1);
    req = '0;
    a0 = ack_cnt;
    repeat (8) @(negedge clk);
    chk("stale_no_ack", ack_cnt - a0, 0);
    m_done = 1'b0;
    @(negedge clk);
    m_done = 1'b1;
    @(negedge clk);
    chk("stale_ack", 32'(ack), 32'h1);
    m_done = 1'b0;
    @(negedge clk);
    chk("stale_gnt_clear", 32'(gnt), 0);
    // reset in the middle of WAIT
    set_fields(2, 1'b1, 7'h33, 8'h00);
    req = 4'b0100;
    @(negedge clk);
    chk("rw_start", 32'(m_start), 1);
    chk("rw_gnt", 32'(gnt), 32'h4);
    req = '0;
    repeat (5) @(negedge clk);
    a0 = ack_cnt;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_gnt", 32'(gnt), 0);
    chk("mid_rst_ack", 32'(ack), 0);
    chk("mid_rst_start", 32'(m_start), 0);
    chk("mid_rst_rw", 32'(m_rw), 0);
    chk("mid_rst_addr", 32'(m_addr), 0);
    chk("mid_rst_wdata", 32'(m_data_in), 0);
    chk("mid_rst_rdata", 32'(rsp_rdata), 0);
    chk("mid_rst_err", 32'(rsp_err), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_no_ack", ack_cnt - a0, 0);
    set_fields(0, 1'b0, 7'h21, 8'h12);
    txn(4'b1111, 0, 2, 8'h21, 1'b0, 1'b0);
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
